// File: rtl/ifu_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ifu_fetch_pkg
//   Shared definitions for the instruction fetch unit.
//   - ifu_state_t : fetch FSM state encoding (3 bits)
//   - RESET_PC    : default fetch address after reset
//   - NOP_INST    : instruction word presented to decode as a bubble
//   - IFU_XLEN    : default address / instruction width
// ----------------------------------------------------------------------------
package ifu_fetch_pkg;

   localparam int          IFU_XLEN = 32;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   // IDLE     : one cycle after reset release, before the first request
   // REQ      : request presented at fetch_pc, waiting for imem_req_ready
   // WAIT     : request accepted, waiting for the response
   // DROP_REQ : redirected while the old request was still unaccepted;
   //            the old address stays on the bus until it is accepted
   // DROP     : old request accepted, its response will be discarded
   typedef enum logic [2:0] {
      IFU_IDLE     = 3'd0,
      IFU_REQ      = 3'd1,
      IFU_WAIT     = 3'd2,
      IFU_DROP_REQ = 3'd3,
      IFU_DROP     = 3'd4
   } ifu_state_t;

endpackage : ifu_fetch_pkg

// File: rtl/ifu_fetch_out_buf.sv
// ----------------------------------------------------------------------------
// ifu_out_buf
//   Single-entry buffer between instruction memory and decode.
//   Holds one fetched {inst, pc}. Decode consumes the entry on any edge where
//   the buffer is valid and pipe_stop is low.
//
//   Ports
//     clk, rst_n   : clock, synchronous active-low reset
//     pipe_stop    : decode stall; blocks consumption
//     flush        : drop the held entry (redirect); wins over load/consume
//     load         : write load_inst/load_pc into the buffer
//     load_inst    : instruction word to store
//     load_pc      : PC of that instruction
//     buf_valid    : buffer holds an instruction
//     buf_inst     : held instruction
//     buf_pc       : PC of the held instruction
//     accept       : buffer can take a new entry this cycle
//                    (empty, or being drained on this same edge)
// ----------------------------------------------------------------------------
module ifu_out_buf #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_stop,
   input  logic            flush,
   input  logic            load,
   input  logic [XLEN-1:0] load_inst,
   input  logic [XLEN-1:0] load_pc,
   output logic            buf_valid,
   output logic [XLEN-1:0] buf_inst,
   output logic [XLEN-1:0] buf_pc,
   output logic            accept
);

   logic consume;

   assign consume = buf_valid & ~pipe_stop;
   // A full buffer may still accept when decode drains it on the same edge,
   // which keeps the zero-wait throughput at one instruction per two cycles.
   assign accept  = ~buf_valid | consume;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_valid <= 1'b0;
         buf_inst  <= '0;
         buf_pc    <= '0;
      end else if (flush) begin
         // Squash even when decode would have consumed this cycle.
         buf_valid <= 1'b0;
      end else if (load) begin
         buf_valid <= 1'b1;
         buf_inst  <= load_inst;
         buf_pc    <= load_pc;
      end else if (consume) begin
         buf_valid <= 1'b0;
      end
   end

endmodule : ifu_out_buf

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
//   RV32 instruction fetch stage. Owns the fetch PC, keeps at most one request
//   outstanding to instruction memory and hands {inst, pc} to decode through
//   a single-entry buffer. Emits bubbles (inst = 0) when nothing is buffered.
//   Redirects (branch / jump / ecall / mret) discard any in-flight fetch.
//
//   Handshakes (both memory channels): a transfer happens on a rising edge
//   where valid and ready are both high. While valid is high and ready is
//   low, the sender holds valid and its payload stable.
//
//   Ports
//     clk, rst_n     : clock, synchronous active-low reset
//     pipe_stop      : decode stall
//     redirect_valid : one-cycle redirect pulse
//     redirect_pc    : redirect target (low two bits ignored)
//     imem_req_*     : request channel (valid/ready/addr)
//     imem_rsp_*     : response channel (valid/ready/data)
//     inst, pc       : instruction and its PC to decode (0 when empty)
//     inst_valid     : buffer valid flag
// ----------------------------------------------------------------------------
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = ifu_fetch_pkg::RESET_PC,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_stop,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   output logic            imem_rsp_ready,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] pc,
   output logic            inst_valid
);

   // FSM state is kept as a named signal so checkers can bind to it.
   ifu_state_t      state;
   ifu_state_t      state_next;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] fetch_pc_next;
   // Address of the request presented in REQ; keeps the old address on the
   // bus in DROP_REQ after fetch_pc has already moved to the redirect target.
   logic [XLEN-1:0] held_addr;

   logic            buf_load;
   logic            buf_accept;
   logic            buf_valid;
   logic [XLEN-1:0] buf_inst;
   logic [XLEN-1:0] buf_pc;

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IFU_IDLE;
         fetch_pc  <= RESET_PC[XLEN-1:0];
         held_addr <= RESET_PC[XLEN-1:0];
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         if (state == IFU_REQ) begin
            held_addr <= fetch_pc;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state, PC update and memory interface outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_next     = state;
      fetch_pc_next  = fetch_pc;
      imem_req_valid = 1'b0;
      imem_req_addr  = fetch_pc;
      imem_rsp_ready = 1'b0;
      buf_load       = 1'b0;

      unique case (state)
         IFU_IDLE: begin
            state_next = IFU_REQ;
         end

         IFU_REQ: begin
            imem_req_valid = 1'b1;
            if (redirect_valid) begin
               // An unaccepted request cannot be withdrawn, so it is
               // completed and its response thrown away.
               state_next = imem_req_ready ? IFU_DROP : IFU_DROP_REQ;
            end else if (imem_req_ready) begin
               state_next = IFU_WAIT;
            end
         end

         IFU_WAIT: begin
            imem_rsp_ready = buf_accept;
            if (imem_rsp_valid && buf_accept) begin
               state_next = IFU_REQ;
               if (!redirect_valid) begin
                  buf_load      = 1'b1;
                  fetch_pc_next = fetch_pc + XLEN'(4);
               end
            end else if (redirect_valid) begin
               state_next = IFU_DROP;
            end
         end

         IFU_DROP_REQ: begin
            imem_req_valid = 1'b1;
            imem_req_addr  = held_addr;
            if (imem_req_ready) begin
               state_next = IFU_DROP;
            end
         end

         IFU_DROP: begin
            // The discarded response never needs buffer space.
            imem_rsp_ready = 1'b1;
            if (imem_rsp_valid) begin
               state_next = IFU_REQ;
            end
         end

         default: begin
            state_next = IFU_IDLE;
         end
      endcase

      // Redirect overrides any PC update made above.
      if (redirect_valid) begin
         fetch_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
      end
   end

   // ------------------------------------------------------------------------
   // Output buffer
   // ------------------------------------------------------------------------
   ifu_out_buf #(
      .XLEN (XLEN)
   ) u_out_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .pipe_stop (pipe_stop),
      .flush     (redirect_valid),
      .load      (buf_load),
      .load_inst (imem_rsp_data),
      .load_pc   (fetch_pc),
      .buf_valid (buf_valid),
      .buf_inst  (buf_inst),
      .buf_pc    (buf_pc),
      .accept    (buf_accept)
   );

   assign inst       = buf_valid ? buf_inst : NOP_INST[XLEN-1:0];
   assign pc         = buf_valid ? buf_pc   : '0;
   assign inst_valid = buf_valid;

endmodule : ifu_fetch

// File: tb/tb_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch
//   Bench for ifu_fetch. A behavioural instruction memory answers requests
//   after a programmable latency and can hold off request acceptance.
//   A reference model of the in-order instruction stream pushes {pc, inst}
//   into exp_q whenever a response for the next expected PC is handed over,
//   and every decode consume pops and compares. Directed sequences cover the
//   stall, redirect and reset corners; a table of redirect targets covers
//   alignment and address wrap.
// ----------------------------------------------------------------------------
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC   = 32'h8000_0000;
   localparam logic [31:0] BAD_INST = 32'hDEAD_BEEF;

   // ---------------------------------------------------------------- clock/reset
   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   logic        pipe_stop;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic        imem_rsp_ready;
   logic [31:0] imem_rsp_data;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;

   ifu_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pipe_stop      (pipe_stop),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_ready (imem_rsp_ready),
      .imem_rsp_data  (imem_rsp_data),
      .inst           (inst),
      .pc             (pc),
      .inst_valid     (inst_valid)
   );

   // ---------------------------------------------------------------- bookkeeping
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];          // {pc, inst} in delivery order
   logic [31:0] model_pc;          // next PC the instruction stream expects

   // memory model state
   bit          pend;
   logic [31:0] pend_addr;
   int          pend_delay;
   int          rsp_lat   = 0;
   bit          req_block = 0;
   int          mem_mode  = 0;
   bit          bad_en    = 0;
   logic [31:0] bad_addr  = 32'h0;

   bit          prev_req_wait;
   logic [31:0] prev_req_addr;

   typedef struct {
      logic [31:0] target;
      logic [31:0] first;
      logic [31:0] second;
   } redir_vec_t;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (bad_en && a == bad_addr) return BAD_INST;
      if (mem_mode == 0) return 32'h0000_0013;
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive_mem();
      imem_rsp_valid = pend && (pend_delay == 0);
      imem_rsp_data  = pend ? mem_data(pend_addr) : 32'h0;
      imem_req_ready = !req_block;
   endtask

   // One clock: sample pre-edge handshakes, advance model and memory at the
   // following negedge, drive new memory outputs.
   task automatic cycle();
      logic        rf, sf, cons, rv, rs;
      logic [31:0] ra, sd, sa, cpc, cinst, rpc;
      logic [63:0] item;
      #1;
      rf    = imem_req_valid & imem_req_ready;
      sf    = imem_rsp_valid & imem_rsp_ready;
      cons  = inst_valid & ~pipe_stop;
      rv    = redirect_valid;
      rs    = rst_n;
      ra    = imem_req_addr;
      sd    = imem_rsp_data;
      sa    = pend_addr;
      cpc   = pc;
      cinst = inst;
      rpc   = redirect_pc;
      prev_req_wait = rs && imem_req_valid && !imem_req_ready;
      prev_req_addr = ra;
      @(posedge clk);
      @(negedge clk);
      if (!rs) begin
         pend = 0;
         exp_q.delete();
         model_pc = RST_PC;
      end else begin
         if (cons && !rv) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got pc %h inst %h, required no instruction", cpc, cinst);
            end else begin
               item = exp_q.pop_front();
               check("sb_pc", cpc, item[63:32]);
               check("sb_inst", cinst, item[31:0]);
            end
         end
         if (rv) begin
            exp_q.delete();
            model_pc = {rpc[31:2], 2'b00};
         end else if (sf && sa == model_pc) begin
            exp_q.push_back({model_pc, sd});
            model_pc = model_pc + 32'd4;
         end
         if (sf) pend = 0;
         if (rf) begin
            pend       = 1;
            pend_addr  = ra;
            pend_delay = rsp_lat;
         end else if (pend && pend_delay > 0) begin
            pend_delay--;
         end
      end
      drive_mem();
      #1;
      if (prev_req_wait) begin
         check("req_hold_valid", imem_req_valid, 1'b1);
         check("req_hold_addr", imem_req_addr, prev_req_addr);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- test body
   initial begin
      redir_vec_t  vecs[4];
      logic [31:0] hold_pc, hold_inst, old_addr, got_addr, a2;
      logic [31:0] fa[2];
      bit          found, saw_drop, saw_bad;
      int          nf;

      vecs[0] = '{target: 32'h8000_4001, first: 32'h8000_4000, second: 32'h8000_4004};
      vecs[1] = '{target: 32'h0000_0003, first: 32'h0000_0000, second: 32'h0000_0004};
      vecs[2] = '{target: 32'hFFFF_FFFE, first: 32'hFFFF_FFFC, second: 32'h0000_0000};
      vecs[3] = '{target: 32'h1234_5678, first: 32'h1234_5678, second: 32'h1234_567C};

      rst_n = 0; pipe_stop = 0; redirect_valid = 0; redirect_pc = 32'h0;
      pend = 0; pend_addr = 32'h0; pend_delay = 0; model_pc = RST_PC;
      drive_mem();

      // ---- reset values
      repeat (3) cycle();
      check("rst_req_valid", imem_req_valid, 1'b0);
      check("rst_rsp_ready", imem_rsp_ready, 1'b0);
      check("rst_inst", inst, 32'h0);
      check("rst_pc", pc, 32'h0);
      check("rst_inst_valid", inst_valid, 1'b0);

      // ---- zero-wait stream: request every other cycle
      rst_n = 1;
      cycle();
      for (int c = 1; c <= 6; c++) begin
         check($sformatf("t1_req_valid_c%0d", c), imem_req_valid, 32'((c % 2) == 1));
         if ((c % 2) == 1) check($sformatf("t1_req_addr_c%0d", c), imem_req_addr, RST_PC + 32'((c - 1) * 2));
         check($sformatf("t1_inst_valid_c%0d", c), inst_valid, 32'(((c % 2) == 1) && c >= 3));
         if ((c % 2) == 1 && c >= 3) begin
            check($sformatf("t1_pc_c%0d", c), pc, RST_PC + 32'((c - 3) * 2));
            check($sformatf("t1_inst_c%0d", c), inst, 32'h0000_0013);
         end
         cycle();
      end

      // ---- decode stall with a full buffer
      mem_mode = 1;
      for (int i = 0; i < 20 && !inst_valid; i++) cycle();
      check("t2_buf_full", inst_valid, 1'b1);
      pipe_stop = 1;
      hold_pc   = pc;
      hold_inst = inst;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("t2_hold_valid", inst_valid, 1'b1);
         check("t2_hold_pc", pc, hold_pc);
         check("t2_hold_inst", inst, hold_inst);
      end
      check("t2_rsp_pending", imem_rsp_valid, 1'b1);
      check("t2_rsp_blocked", imem_rsp_ready, 1'b0);
      check("t2_no_new_req", imem_req_valid, 1'b0);
      pipe_stop = 0;
      cycle();
      check("t2_next_valid", inst_valid, 1'b1);
      check("t2_next_pc", pc, hold_pc + 32'd4);
      repeat (8) cycle();

      // ---- redirect while waiting for a slow response
      rsp_lat = 3;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req_valid && imem_req_ready) found = 1;
         else cycle();
      end
      check("t3_req_seen", found, 1'b1);
      bad_addr = imem_req_addr;
      bad_en   = 1;
      cycle();
      redirect_valid = 1;
      redirect_pc    = 32'h8000_1002;
      cycle();
      redirect_valid = 0;
      rsp_lat  = 0;
      saw_drop = 0; saw_bad = 0; found = 0; got_addr = 32'h0;
      for (int i = 0; i < 15 && !found; i++) begin
         if (imem_rsp_valid && imem_rsp_ready && imem_rsp_data == BAD_INST) saw_drop = 1;
         if (inst_valid && inst == BAD_INST) saw_bad = 1;
         if (imem_req_valid && imem_req_ready) begin
            found    = 1;
            got_addr = imem_req_addr;
         end
         cycle();
      end
      check("t3_new_req_seen", found, 1'b1);
      check("t3_new_req_addr", got_addr, 32'h8000_1000);
      check("t3_late_rsp_taken", saw_drop, 1'b1);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (inst_valid) found = 1;
         else begin
            if (inst == BAD_INST) saw_bad = 1;
            cycle();
         end
      end
      check("t3_bad_never_shown", saw_bad, 1'b0);
      check("t3_target_pc", pc, 32'h8000_1000);
      bad_en = 0;

      // ---- redirect while the request is not yet accepted
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_rsp_valid && imem_rsp_ready) found = 1;
         else cycle();
      end
      check("t4_rsp_seen", found, 1'b1);
      req_block      = 1;
      imem_req_ready = 0;
      cycle();
      check("t4_req_valid", imem_req_valid, 1'b1);
      old_addr       = imem_req_addr;
      redirect_valid = 1;
      redirect_pc    = 32'h8000_2000;
      cycle();
      redirect_valid = 0;
      for (int i = 0; i < 2; i++) begin
         check("t4_old_valid", imem_req_valid, 1'b1);
         check("t4_old_addr", imem_req_addr, old_addr);
         cycle();
      end
      req_block      = 0;
      imem_req_ready = 1;
      nf = 0; fa[0] = 32'h0; fa[1] = 32'h0;
      for (int i = 0; i < 20 && nf < 2; i++) begin
         if (imem_req_valid && imem_req_ready) begin
            fa[nf] = imem_req_addr;
            nf++;
         end
         cycle();
      end
      check("t4_fire_count", nf, 2);
      check("t4_first_fire", fa[0], old_addr);
      check("t4_second_fire", fa[1], 32'h8000_2000);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (inst_valid) found = 1;
         else cycle();
      end
      check("t4_target_pc", pc, 32'h8000_2000);

      // ---- redirect on the same edge as consume and response
      pipe_stop = 1;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (inst_valid && imem_rsp_valid && !imem_rsp_ready) found = 1;
         else cycle();
      end
      check("t5_setup", found, 1'b1);
      pipe_stop      = 0;
      redirect_valid = 1;
      redirect_pc    = 32'h8000_3000;
      #1;
      check("t5_rsp_ready", imem_rsp_ready, 1'b1);
      cycle();
      redirect_valid = 0;
      check("t5_cleared_valid", inst_valid, 1'b0);
      check("t5_cleared_inst", inst, 32'h0);
      check("t5_cleared_pc", pc, 32'h0);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (inst_valid) found = 1;
         else cycle();
      end
      check("t5_target_pc", pc, 32'h8000_3000);
      check("t5_target_inst", inst, mem_data(32'h8000_3000));

      // ---- reset during WAIT
      rsp_lat = 3;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req_valid && imem_req_ready) found = 1;
         else cycle();
      end
      cycle();
      rst_n = 0;
      cycle();
      check("t6_req_valid", imem_req_valid, 1'b0);
      check("t6_rsp_ready", imem_rsp_ready, 1'b0);
      check("t6_inst", inst, 32'h0);
      check("t6_pc", pc, 32'h0);
      check("t6_inst_valid", inst_valid, 1'b0);
      rsp_lat = 0;
      rst_n   = 1;
      cycle();
      check("t6_first_req_valid", imem_req_valid, 1'b1);
      check("t6_first_req_addr", imem_req_addr, RST_PC);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (inst_valid) found = 1;
         else cycle();
      end
      check("t6_first_pc", pc, RST_PC);

      // ---- redirect target table (alignment, wrap) with random stalls
      for (int v = 0; v < 4; v++) begin
         repeat ($urandom_range(0, 3)) begin
            pipe_stop = ($urandom_range(0, 3) == 0);
            cycle();
         end
         redirect_valid = 1;
         redirect_pc    = vecs[v].target;
         cycle();
         redirect_valid = 0;
         nf = 0;
         a2 = 32'hFFFF_FFFF;
         for (int i = 0; i < 40 && nf < 2; i++) begin
            pipe_stop = ($urandom_range(0, 3) == 0);
            if (imem_req_valid && imem_req_ready) begin
               if (nf == 0) begin
                  if (imem_req_addr == vecs[v].first) nf = 1;
               end else begin
                  a2 = imem_req_addr;
                  nf = 2;
               end
            end
            cycle();
         end
         check($sformatf("tv%0d_target_req", v), 32'(nf != 0), 32'd1);
         check($sformatf("tv%0d_next_req", v), a2, vecs[v].second);
      end
      pipe_stop = 0;
      repeat (10) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_ifu_fetch

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage of the RV32 in-order pipeline. It sits directly upstream of the decode stage.
- Owns the fetch PC and issues one outstanding request at a time to instruction memory over a valid/ready request and response interface.
- Holds each returned instruction in a single-entry output buffer and presents {inst, pc} to decode.
- Inserts bubbles (inst = 0, which decode treats as a no-op) when no instruction is ready.
- Redirects on branch, jump, ecall and mret.

Parameters:
RESET_PC, 32'h8000_0000, fetch address after reset
XLEN, 32, address and instruction width

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  reset, synchronous, active-low (sampled on posedge clk)
pipe_stop  in  1  decode stall; decode holds its input registers this cycle
redirect_valid  in  1  one-cycle pulse: a branch was taken, or jump/ecall/mret resolved
redirect_pc  in  32  new fetch target (mtvec, mepc or branch/jump target)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word address of the request
imem_rsp_valid  in  1  response data valid
imem_rsp_ready  out  1  fetch accepts response
imem_rsp_data  in  32  instruction word
inst  out  32  instruction to decode; 32'h0 when buf_valid = 0
pc  out  32  PC of inst; buf_pc, or 0 when buf_valid = 0
inst_valid  out  1  buf_valid, for the hazard unit and perf counters

Behaviour:
- Internal state: fetch_pc[31:0]; buf_valid, buf_inst, buf_pc; FSM state.
- FSM states: IDLE, REQ, WAIT, DROP_REQ, DROP.
- Reset (rst_n = 0 at posedge):
  - fetch_pc = RESET_PC, state = IDLE, buf_valid = 0.
  - Outputs: imem_req_valid = 0, imem_rsp_ready = 0, inst = 0, pc = 0, inst_valid = 0.
  - Reset mid-transaction abandons the outstanding request; the memory model is reset by the same rst_n.
- Handshakes:
  - req_fire = imem_req_valid & imem_req_ready.
  - rsp_fire = imem_rsp_valid & imem_rsp_ready.
  - consume = buf_valid & ~pipe_stop. Decode latches inst at this edge.
- FSM transitions, absent redirect:
  - IDLE -> REQ unconditionally, one cycle after reset release.
  - REQ: imem_req_valid = 1, addr = fetch_pc. On req_fire -> WAIT. While waiting for ready, addr and valid are held stable.
  - WAIT: imem_rsp_ready = ~buf_valid | consume. On rsp_fire:
    - buf_inst <= rsp_data, buf_pc <= fetch_pc, buf_valid <= 1.
    - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
    - -> REQ.
  - Buffer drain: consume without a same-cycle rsp_fire sets buf_valid <= 0.
- Redirect (redirect_valid = 1) has priority over every other event in the same cycle:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; buf_valid <= 0. The held instruction is squashed even when consume is 1.
  - IDLE/REQ without req_fire: in IDLE -> REQ; in REQ -> DROP_REQ, because the old address is still presented and must complete.
  - REQ with req_fire -> DROP.
  - WAIT without rsp_fire -> DROP.
  - WAIT with rsp_fire: response discarded -> REQ.
  - DROP_REQ: keeps the old request; on req_fire -> DROP.
  - DROP: imem_rsp_ready = 1; on rsp_fire the data is discarded -> REQ at the new fetch_pc.
  - Redirect while in DROP or DROP_REQ: update fetch_pc only; state unchanged.
- Latency: redirect at edge N puts the new target on imem_req_addr from cycle N+1, or after the drop completes. With zero-wait memory, one instruction is delivered every 2 cycles (request cycle plus response cycle).
- pipe_stop with an empty buffer has no effect on fetch. pipe_stop with a full buffer blocks rsp_ready, so backpressure reaches memory.
- No fetch-side exceptions. Misaligned redirect_pc low bits are silently cleared.

Decomposition:
- Shared package/defines (alongside the existing para defines):
  - FSM state encodings, 3-bit: IFU_IDLE, IFU_REQ, IFU_WAIT, IFU_DROP_REQ, IFU_DROP.
  - RESET_PC constant.
  - NOP_INST = 32'h0.
- One sub-module: ifu_out_buf, the single-entry buffer with load/consume/flush and the ready calculation.
- The FSM and PC stay in the top level.

Test Plan:
- Reset release, zero-wait memory returning 0x00000013 at every address:
  - Requests go to 0x80000000, 0x80000004, 0x80000008 on cycles 1, 3, 5.
  - inst_valid pulses with pc matching each address.
- pipe_stop held for 5 cycles while buf_valid = 1:
  - buf_inst and pc stay stable.
  - imem_rsp_ready = 0 when a response arrives.
  - No PC advance until pipe_stop falls.
  - Nothing lost or duplicated.
- Redirect to 0x80001002 while in WAIT:
  - The late response (data 0xDEADBEEF) is accepted and discarded; inst_valid never shows it.
  - The next request address is 0x80001000.
- Redirect while in REQ with imem_req_ready = 0 for 3 cycles:
  - Old address held stable until accepted, then its response is dropped.
  - The following request is to the redirect target.
- Redirect on the same edge as consume and rsp_fire:
  - Buffer cleared; the response is dropped.
  - The next visible pc equals the redirect target.
- rst_n low during WAIT:
  - All outputs return to reset values next edge.
  - After release, the first request is 0x80000000.
